// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Purpose  : Shared types and constants for the N-source interrupt controller.
// Revision : 1.0
// ============================================================================
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        FIN   = 2'd2
    } irq_state_t;

    localparam int MCAUSE_IRQ_BASE = 16;
    localparam int IRQ_MAX_SRC     = 32;
    localparam int IRQ_IDX_W       = 5;

    // Interrupt bit plus platform-specific cause number.
    function automatic logic [31:0] irq_mcause(input logic [IRQ_IDX_W-1:0] idx);
        return 32'h8000_0000 | (32'(MCAUSE_IRQ_BASE) + 32'(idx));
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : irq_arbiter
// Purpose  : Combinational find-first-set searching upward from a start index,
//            wrapping modulo N. Fixed mode always searches from index 0.
// Revision : 1.0
// ============================================================================
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int N  = 8,
    parameter bit RR = 1'b0
) (
    input  logic [N-1:0]           req,
    input  logic [IRQ_IDX_W-1:0]   start,
    output logic                   valid,
    output logic [IRQ_IDX_W-1:0]   idx
);

    localparam int SUM_W = IRQ_IDX_W + 1;

    logic [IRQ_IDX_W-1:0] w_start;
    logic [N-1:0]         w_rot;
    logic [SUM_W-1:0]     w_sum;

    assign w_start = RR ? start : '0;
    // Rotating the doubled vector puts the start index at bit 0.
    assign w_rot   = N'({req, req} >> w_start);

    always_comb begin
        valid = 1'b0;
        w_sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                valid = 1'b1;
                w_sum = {1'b0, w_start} + SUM_W'(k);
            end
        end
        if (w_sum >= SUM_W'(N)) begin
            w_sum = w_sum - SUM_W'(N);
        end
        idx = w_sum[IRQ_IDX_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_n
// Purpose  : N-source interrupt controller with edge/level sources, mie
//            masking, fixed or round-robin arbitration and INT/INT_RST handshake.
// Revision : 1.0
// ============================================================================
module irq_ctrl_n
    import irq_pkg::*;
#(
    parameter int               N_SRC     = 8,
    parameter int               RR_MODE   = 0,
    parameter logic [N_SRC-1:0] EDGE_MASK = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] int_req_i,
    input  logic [31:0]      mie_i,
    input  logic             INT_RST_i,
    output logic             INT_o,
    output logic [31:0]      mcause_o,
    output logic [N_SRC-1:0] int_fin_o,
    output logic [N_SRC-1:0] pending_o
);

    irq_state_t             r_state, w_state_next;
    logic [N_SRC-1:0]       r_req_q, r_req_d, r_pend, r_fin;
    logic [IRQ_IDX_W-1:0]   r_rr_ptr, r_idx;
    logic                   r_int;
    logic [31:0]            r_mcause;

    logic [N_SRC-1:0]       w_rise, w_onehot, w_clr, w_masked, w_pend_next, w_fin_next;
    logic [IRQ_IDX_W-1:0]   w_rr_next, w_idx_next, w_arb_idx;
    logic                   w_arb_valid, w_int_next;
    logic [31:0]            w_mcause_next;
    logic                   w_unused_mie;

    assign w_unused_mie = ^mie_i;
    assign w_rise       = r_req_q & ~r_req_d;
    assign w_masked     = r_pend & mie_i[N_SRC-1:0];
    assign w_clr        = (r_state == FIN) ? w_onehot : '0;

    always_comb begin
        w_onehot    = '0;
        w_pend_next = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_onehot[i] = (r_idx == IRQ_IDX_W'(i));
            // A fresh edge beats the completion clear in the same cycle.
            if (EDGE_MASK[i]) begin
                w_pend_next[i] = w_rise[i] | (r_pend[i] & ~w_clr[i]);
            end else begin
                w_pend_next[i] = r_req_q[i];
            end
        end
    end

    irq_arbiter #(
        .N  (N_SRC),
        .RR (RR_MODE != 0)
    ) u_arbiter (
        .req   (w_masked),
        .start (r_rr_ptr),
        .valid (w_arb_valid),
        .idx   (w_arb_idx)
    );

    always_comb begin
        w_state_next  = r_state;
        w_int_next    = r_int;
        w_mcause_next = r_mcause;
        w_fin_next    = '0;
        w_idx_next    = r_idx;
        w_rr_next     = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_idx_next    = w_arb_idx;
                    w_mcause_next = irq_mcause(w_arb_idx);
                    w_int_next    = 1'b1;
                    w_state_next  = SERVE;
                end
            end
            SERVE: begin
                if (INT_RST_i) begin
                    w_int_next   = 1'b0;
                    w_fin_next   = w_onehot;
                    w_state_next = FIN;
                end
            end
            FIN: begin
                if (RR_MODE != 0) begin
                    w_rr_next = (r_idx == IRQ_IDX_W'(N_SRC - 1)) ? '0 : r_idx + 1'b1;
                end
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_req_q  <= '0;
            r_req_d  <= '0;
            r_pend   <= '0;
            r_rr_ptr <= '0;
            r_idx    <= '0;
            r_int    <= 1'b0;
            r_mcause <= '0;
            r_fin    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_req_q  <= int_req_i;
            r_req_d  <= r_req_q;
            r_pend   <= w_pend_next;
            r_rr_ptr <= w_rr_next;
            r_idx    <= w_idx_next;
            r_int    <= w_int_next;
            r_mcause <= w_mcause_next;
            r_fin    <= w_fin_next;
        end
    end

    assign INT_o     = r_int;
    assign mcause_o  = r_mcause;
    assign int_fin_o = r_fin;
    assign pending_o = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl_n
// Purpose  : Directed self-checking bench: fixed-priority instance (source 4
//            level-triggered) and round-robin instance (all edge-triggered).
// Revision : 1.0
// ============================================================================
module tb_irq_ctrl_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  req_a = '0, req_b = '0;
    logic [31:0] mie_a = '0, mie_b = '0;
    logic        ack_a = 1'b0, ack_b = 1'b0;
    logic        int_a, int_b;
    logic [31:0] mc_a, mc_b;
    logic [7:0]  fin_a, fin_b, pend_a, pend_b;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    irq_ctrl_n #(.N_SRC(8), .RR_MODE(0), .EDGE_MASK(8'hEF)) dut_a (
        .clk_i(clk), .rst_i(rst), .int_req_i(req_a), .mie_i(mie_a), .INT_RST_i(ack_a),
        .INT_o(int_a), .mcause_o(mc_a), .int_fin_o(fin_a), .pending_o(pend_a)
    );

    irq_ctrl_n #(.N_SRC(8), .RR_MODE(1), .EDGE_MASK(8'hFF)) dut_b (
        .clk_i(clk), .rst_i(rst), .int_req_i(req_b), .mie_i(mie_b), .INT_RST_i(ack_b),
        .INT_o(int_b), .mcause_o(mc_b), .int_fin_o(fin_b), .pending_o(pend_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (int_a !== 1'b0) $display("FAIL reset_int got %0b want 0", int_a); else n_pass++;
        n_checks++; if (mc_a !== 32'h0) $display("FAIL reset_mcause got %h want 0", mc_a); else n_pass++;
        n_checks++; if (fin_a !== 8'h00 || fin_b !== 8'h00) $display("FAIL reset_fin got %h/%h want 00", fin_a, fin_b); else n_pass++;
        n_checks++; if (pend_b !== 8'h00 || int_b !== 1'b0) $display("FAIL reset_b got pend %h int %0b want 0", pend_b, int_b); else n_pass++;
    endtask

    task automatic test_fixed_priority();
        mie_a = 32'h0000_00FF;
        req_a = 8'h24;
        tick();
        req_a = 8'h00;
        tick();
        n_checks++; if (pend_a !== 8'h24) $display("FAIL fx_pend got %h want 24", pend_a); else n_pass++;
        n_checks++; if (int_a !== 1'b0) $display("FAIL fx_latency got %0b want 0", int_a); else n_pass++;
        tick();
        n_checks++; if (int_a !== 1'b1 || mc_a !== 32'h8000_0012) $display("FAIL fx_first got int %0b mcause %h want 1 80000012", int_a, mc_a); else n_pass++;
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        n_checks++; if (int_a !== 1'b0 || fin_a !== 8'h04) $display("FAIL fx_fin1 got int %0b fin %h want 0 04", int_a, fin_a); else n_pass++;
        tick();
        n_checks++; if (int_a !== 1'b0 || fin_a !== 8'h00 || pend_a !== 8'h20) $display("FAIL fx_gap got int %0b fin %h pend %h want 0 00 20", int_a, fin_a, pend_a); else n_pass++;
        tick();
        n_checks++; if (int_a !== 1'b1 || mc_a !== 32'h8000_0015) $display("FAIL fx_second got int %0b mcause %h want 1 80000015", int_a, mc_a); else n_pass++;
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        n_checks++; if (fin_a !== 8'h20) $display("FAIL fx_fin2 got %h want 20", fin_a); else n_pass++;
        tick();
        n_checks++; if (pend_a !== 8'h00 || fin_a !== 8'h00) $display("FAIL fx_done got pend %h fin %h want 00 00", pend_a, fin_a); else n_pass++;
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        tick();
        n_checks++; if (int_a !== 1'b0 || fin_a !== 8'h00) $display("FAIL fx_idle_ack got int %0b fin %h want 0 00", int_a, fin_a); else n_pass++;
    endtask

    task automatic test_masking();
        mie_a = 32'hFFFF_FF00;
        req_a = 8'h08;
        tick();
        req_a = 8'h00;
        tick();
        tick();
        tick();
        n_checks++; if (int_a !== 1'b0 || pend_a !== 8'h08) $display("FAIL mask_hold got int %0b pend %h want 0 08", int_a, pend_a); else n_pass++;
        mie_a = 32'h0000_0008;
        tick();
        n_checks++; if (int_a !== 1'b1 || mc_a !== 32'h8000_0013) $display("FAIL mask_release got int %0b mcause %h want 1 80000013", int_a, mc_a); else n_pass++;
        mie_a = 32'h0;
        tick();
        n_checks++; if (int_a !== 1'b1 || mc_a !== 32'h8000_0013) $display("FAIL mask_in_serve got int %0b mcause %h want 1 80000013", int_a, mc_a); else n_pass++;
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        n_checks++; if (fin_a !== 8'h08) $display("FAIL mask_fin got %h want 08", fin_a); else n_pass++;
        tick();
        n_checks++; if (pend_a !== 8'h00) $display("FAIL mask_clear got %h want 00", pend_a); else n_pass++;
    endtask

    task automatic test_level();
        mie_a = 32'h0000_0010;
        req_a = 8'h10;
        tick();
        tick();
        tick();
        n_checks++; if (int_a !== 1'b1 || mc_a !== 32'h8000_0014) $display("FAIL lvl_first got int %0b mcause %h want 1 80000014", int_a, mc_a); else n_pass++;
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        n_checks++; if (int_a !== 1'b0 || fin_a !== 8'h10) $display("FAIL lvl_fin1 got int %0b fin %h want 0 10", int_a, fin_a); else n_pass++;
        tick();
        n_checks++; if (int_a !== 1'b0) $display("FAIL lvl_gap got %0b want 0", int_a); else n_pass++;
        tick();
        n_checks++; if (int_a !== 1'b1) $display("FAIL lvl_reraise got %0b want 1", int_a); else n_pass++;
        req_a = 8'h00;
        tick();
        tick();
        n_checks++; if (pend_a !== 8'h00 || int_a !== 1'b1) $display("FAIL lvl_drop got pend %h int %0b want 00 1", pend_a, int_a); else n_pass++;
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        n_checks++; if (fin_a !== 8'h10) $display("FAIL lvl_fin2 got %h want 10", fin_a); else n_pass++;
        tick();
        tick();
        tick();
        n_checks++; if (int_a !== 1'b0 || pend_a !== 8'h00) $display("FAIL lvl_quiet got int %0b pend %h want 0 00", int_a, pend_a); else n_pass++;
    endtask

    task automatic test_collision();
        mie_a = 32'h0000_00FF;
        req_a = 8'h04;
        tick();
        req_a = 8'h00;
        tick();
        tick();
        n_checks++; if (int_a !== 1'b1 || mc_a !== 32'h8000_0012) $display("FAIL col_first got int %0b mcause %h want 1 80000012", int_a, mc_a); else n_pass++;
        ack_a = 1'b1;
        req_a = 8'h04;
        tick();
        ack_a = 1'b0;
        req_a = 8'h00;
        n_checks++; if (fin_a !== 8'h04) $display("FAIL col_fin got %h want 04", fin_a); else n_pass++;
        tick();
        n_checks++; if (pend_a !== 8'h04) $display("FAIL col_repend got %h want 04", pend_a); else n_pass++;
        tick();
        n_checks++; if (int_a !== 1'b1 || mc_a !== 32'h8000_0012) $display("FAIL col_second got int %0b mcause %h want 1 80000012", int_a, mc_a); else n_pass++;
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        tick();
        n_checks++; if (pend_a !== 8'h00 || int_a !== 1'b0) $display("FAIL col_done got pend %h int %0b want 00 0", pend_a, int_a); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_mc  [4];
        logic [7:0]  exp_fin [4];
        logic [7:0]  repulse [4];
        exp_mc  = '{32'h8000_0010, 32'h8000_0011, 32'h8000_0010, 32'h8000_0011};
        exp_fin = '{8'h01, 8'h02, 8'h01, 8'h02};
        repulse = '{8'h01, 8'h02, 8'h00, 8'h00};
        mie_b = 32'h0000_00FF;
        req_b = 8'h03;
        tick();
        req_b = 8'h00;
        tick();
        tick();
        for (int r = 0; r < 4; r++) begin
            n_checks++; if (int_b !== 1'b1 || mc_b !== exp_mc[r]) $display("FAIL rr_serve%0d got int %0b mcause %h want 1 %h", r, int_b, mc_b, exp_mc[r]); else n_pass++;
            ack_b = 1'b1;
            req_b = repulse[r];
            tick();
            ack_b = 1'b0;
            req_b = 8'h00;
            n_checks++; if (fin_b !== exp_fin[r]) $display("FAIL rr_fin%0d got %h want %h", r, fin_b, exp_fin[r]); else n_pass++;
            tick();
            tick();
        end
        n_checks++; if (int_b !== 1'b0 || pend_b !== 8'h00) $display("FAIL rr_done got int %0b pend %h want 0 00", int_b, pend_b); else n_pass++;
    endtask

    task automatic test_reset_mid_serve();
        mie_a = 32'h0000_00FF;
        req_a = 8'h08;
        tick();
        req_a = 8'h00;
        tick();
        tick();
        n_checks++; if (int_a !== 1'b1) $display("FAIL rst_pre got %0b want 1", int_a); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (int_a !== 1'b0 || mc_a !== 32'h0 || fin_a !== 8'h00 || pend_a !== 8'h00) $display("FAIL rst_mid got int %0b mcause %h fin %h pend %h want all 0", int_a, mc_a, fin_a, pend_a); else n_pass++;
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        tick();
        n_checks++; if (int_a !== 1'b0 || fin_a !== 8'h00) $display("FAIL rst_idle got int %0b fin %h want 0 00", int_a, fin_a); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_masking();
        test_level();
        test_collision();
        test_round_robin();
        test_reset_mid_serve();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
